// File: rtl/counter_ctrl_pkg.sv
// ------------------------------------------------------------------
// counter_ctrl_pkg : shared types for the counter command sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package counter_ctrl_pkg;

  localparam int C_DATA_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC_LOAD = 2'd1,
    ST_EXEC_RUN  = 2'd2,
    ST_EXEC_NOP  = 2'd3
  } state_e;

  typedef struct packed {
    op_e                 op;
    logic [C_DATA_W-1:0] arg;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/counter_cmd_fifo.sv
// ------------------------------------------------------------------
// counter_cmd_fifo : synchronous command FIFO, extra-MSB pointers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module counter_cmd_fifo
  import counter_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o = (r_wr_ptr == r_rd_ptr);

  // Flush wins over any same-cycle push or pop.
  assign w_do_push = push_i && !full_o && !flush_i;
  assign w_do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  assign head_o = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ------------------------------------------------------------------
// counter_ctrl : command sequencer driving the 4-bit counter pins
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = C_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_arg_i,
  input  logic [DATA_W-1:0] count_i,
  output logic              enable_o,
  output logic              load_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wrap_o
);

  localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

  cmd_t              w_push_cmd;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_free;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_enable;
  logic              w_enable_nxt;
  logic              r_load;
  logic              w_load_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_wrap;
  logic              r_ready_en;

  assign w_push_cmd.op  = op_e'(cmd_op_i);
  assign w_push_cmd.arg = cmd_arg_i;

  // Ready stays low through reset and the first edge after release.
  assign cmd_ready_o = r_ready_en && !w_full;

  counter_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .data_i  (w_push_cmd),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_enable_nxt = 1'b0;
    w_load_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_pop        = 1'b0;
    // Free means idle or in the last cycle of the current command.
    w_free       = (r_state != ST_EXEC_RUN) || (r_cnt == '0);

    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_free && !w_empty) begin
      w_pop = 1'b1;
      case (w_head.op)
        OP_LOAD, OP_CLEAR: begin
          w_state_nxt  = ST_EXEC_LOAD;
          w_enable_nxt = 1'b1;
          w_load_nxt   = 1'b1;
          w_done_nxt   = 1'b1;
          w_data_nxt   = (w_head.op == OP_LOAD) ? w_head.arg : '0;
        end
        OP_RUN: begin
          w_state_nxt  = ST_EXEC_RUN;
          w_cnt_nxt    = w_head.arg;
          w_enable_nxt = 1'b1;
          w_done_nxt   = (w_head.arg == '0);
        end
        default: begin
          w_state_nxt = ST_EXEC_NOP;
          w_done_nxt  = 1'b1;
        end
      endcase
    end else if (w_free) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_cnt_nxt    = r_cnt - C_ONE;
      w_enable_nxt = 1'b1;
      w_done_nxt   = (r_cnt == C_ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_enable   <= 1'b0;
      r_load     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_enable   <= w_enable_nxt;
      r_load     <= w_load_nxt;
      r_done     <= w_done_nxt;
      r_ready_en <= 1'b1;
      // Evaluated from the cycle before the edge, so flush does not mask it.
      r_wrap     <= r_enable && !r_load && (count_i == '1);
    end
  end

  assign enable_o = r_enable;
  assign load_o   = r_load;
  assign data_o   = r_data;
  assign done_o   = r_done;
  assign wrap_o   = r_wrap;
  assign busy_o   = (r_state != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Command sequencer directly upstream of the 4-bit counter. It accepts LOAD/RUN/CLEAR/NOP commands over a valid/ready interface and buffers them in a small FIFO. It drives the counter's enable/load/data inputs cycle by cycle, and watches the counter's count output to flag wrap-around. Software-facing logic issues commands; this block turns them into counter pin activity.

Parameters:
FIFO_DEPTH, 4, command buffer entries; power of 2, >=2
DATA_W, 4, counter data width; must match the counter

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort: empty FIFO, cancel current command
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  FIFO can accept a command
cmd_op_i  input  2  00 NOP, 01 LOAD, 10 RUN, 11 CLEAR
cmd_arg_i  input  DATA_W  LOAD value, or RUN length minus 1
count_i  input  DATA_W  counter's current count (feedback)
enable_o  output  1  to counter enable_i
load_o  output  1  to counter load_i
data_o  output  DATA_W  to counter data_i
busy_o  output  1  command executing or FIFO non-empty
done_o  output  1  one-cycle pulse in the final cycle of each command
wrap_o  output  1  one-cycle pulse when the counter has wrapped max->0

Behaviour:
- Reset (rst_ni low, async): FIFO empty, state IDLE. enable_o, load_o, done_o, wrap_o and busy_o are 0. data_o is 0. cmd_ready_o is 1 one cycle after reset release, and 0 while in reset.
- Handshake: push when cmd_valid_i && cmd_ready_o at a clock edge. cmd_ready_o = !full, computed from the registered occupancy only. When full, ready stays low even in a cycle that pops. Producer may hold valid; no combinational valid->ready path.
- All counter-facing outputs are registered.
- Latency: command accepted at edge k is popped at edge k+1 if the FSM is free. Outputs are driven after edge k+1, and the counter acts at edge k+2.
- FSM states: IDLE, EXEC_LOAD, EXEC_RUN, EXEC_NOP.
  - IDLE: on FIFO non-empty, pop and go to EXEC_* for that op. Otherwise stay, with all drive outputs 0.
  - EXEC_LOAD (one cycle): enable_o=1, load_o=1, data_o=arg, done_o=1.
  - CLEAR behaves identically with data_o=0.
  - EXEC_RUN: enable_o=1, load_o=0 for exactly arg+1 cycles. arg=0 gives 1 increment; arg=15 gives 16 increments. An internal down-counter is loaded with arg. done_o=1 in the cycle the down-counter is 0.
  - EXEC_NOP: one cycle, enable_o=0, done_o=1.
- Back-to-back: in the final cycle of any command, if the FIFO is non-empty, pop and go directly to the next EXEC state with no idle bubble. Otherwise go to IDLE.
- data_o holds its last value when not loading. It is a don't-care for the counter, but it must be deterministic.
- wrap_o: registered version of (enable_o && !load_o && count_i == all-ones). It is high in the cycle the counter shows 0 after wrapping. A LOAD that loads 0 is not a wrap.
- flush_i (sync, highest priority after reset):
  - At the next edge: FIFO empty, state IDLE, enable_o/load_o/done_o 0.
  - An aborted command produces no done_o.
  - A cmd push in the same cycle as flush is dropped.
  - wrap_o is still computed from the pre-flush cycle.
- busy_o = (state != IDLE) || !empty.
- Counter's own synchronous reset is outside this block. If the counter resets mid-RUN, this block continues its sequence unchanged.

Decomposition:
- Package counter_ctrl_pkg:
  - op enum (OP_NOP, OP_LOAD, OP_RUN, OP_CLEAR)
  - FSM state enum
  - packed cmd struct {op, arg}
  - constant DATA_W default
- Sub-module counter_cmd_fifo: synchronous FIFO of cmd structs.
  - Signals: push, pop, flush, full, empty, head data.
  - Pointer wrap uses an extra MSB.
  - Same clk_i/rst_ni.

Test Plan:
- Reset release, then push LOAD 0x9 at edge k -> enable_o=load_o=1, data_o=9 for one cycle after edge k+1. done_o is high that same cycle, and count_i=9 after edge k+2.
- LOAD 0xD then RUN arg=3 back-to-back -> 1 load cycle, then exactly 4 enable cycles with no bubble. Count goes 13,14,15,0,1. wrap_o pulses once when the count shows 0, and done_o fires twice.
- Push 4 commands with the FSM held in a long RUN (arg=15) -> cmd_ready_o drops to 0 after the 4th. A 5th valid is held and not accepted until the first pop, after which ready returns to 1.
- RUN arg=15 with flush_i asserted on the 6th enable cycle -> enable_o=0 from the next cycle. No done_o, FIFO empty, busy_o=0, and the concurrent push is dropped.
- CLEAR, then NOP -> load of 0 for one cycle with wrap_o=0. This is followed by one NOP cycle with done_o=1 and enable_o=0.
- Assert rst_ni low asynchronously mid-RUN -> all outputs 0 immediately without waiting for a clock edge. FIFO is empty after release.
